// File: rtl/checked_mem_pkg.sv
// checked_mem_pkg: shared types and the address legality helper for checked_mem.
//   state_e  : controller states (ST_INIT writes INIT_VAL, ST_RUN serves requests)
//   range_t  : legality flag plus zero-based entry index
//   in_range : signed bounds check of an address against [base, base+depth-1]
package checked_mem_pkg;

  localparam int unsigned IDX_W = 32;
  localparam int unsigned ADDR_EXT_W = 64;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic             legal;
    logic [IDX_W-1:0] index;
  } range_t;

  // Addresses arrive sign-extended to 64 bits so the subtraction cannot overflow.
  function automatic range_t in_range(input logic signed [ADDR_EXT_W-1:0] addr,
                                      input logic signed [ADDR_EXT_W-1:0] base,
                                      input int unsigned                  depth);
    logic signed [ADDR_EXT_W-1:0] off;
    logic signed [ADDR_EXT_W-1:0] lim;
    range_t                       r;
    off     = addr - base;
    lim     = $signed(ADDR_EXT_W'(depth));
    r.legal = (off >= 64'sd0) && (off < lim);
    r.index = IDX_W'(off);
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clear      : synchronous clear, takes priority over inc
//   count      : registered count value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/checked_mem.sv
// checked_mem: single-port synchronous-read memory with signed-address bounds checking.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (ready only in RUN with a free response slot)
//   req_we                : 1 = write, 0 = read
//   req_addr              : signed address, legal range BASE..BASE+DEPTH-1
//   req_wdata             : write data
//   rsp_valid/rsp_ready   : one-deep read response handshake
//   rsp_data, rsp_oob     : read data (OOB_DATA when out of range) and out-of-range flag
//   oob_count             : saturating count of out-of-range reads and writes
//   init_done             : every entry has been loaded with INIT_VAL
module checked_mem
  import checked_mem_pkg::*;
#(
  parameter int unsigned     WIDTH    = 8,
  parameter int unsigned     DEPTH    = 3,
  parameter int              BASE     = 0,
  parameter int unsigned     AW       = 32,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter logic [WIDTH-1:0] OOB_DATA = '0,
  parameter int unsigned     COUNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic signed [AW-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_oob,
  output logic [COUNT_W-1:0]   oob_count,
  output logic                 init_done
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state;
  logic [IW-1:0]    init_idx;
  logic [WIDTH-1:0] mem [DEPTH];

  range_t           rng;
  logic [IW-1:0]    idx;
  logic             acc;
  logic             rd_acc;
  logic             wr_acc;

  // Address decode and handshake
  assign rng       = in_range(ADDR_EXT_W'(req_addr), ADDR_EXT_W'(BASE), DEPTH);
  assign idx       = IW'(rng.index);
  assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_we;
  assign wr_acc    = acc && req_we;

  // Storage: INIT sweeps INIT_VAL through every entry, RUN takes legal writes
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_idx] <= INIT_VAL;
    end else if (wr_acc && rng.legal) begin
      mem[idx] <= req_wdata;
    end
  end

  // Controller and registered response slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_idx  <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_oob   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_idx == IW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            init_idx <= init_idx + IW'(1);
          end
        end
        ST_RUN: begin
          // A newly accepted read overwrites the slot even while it is being drained
          if (rd_acc) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rng.legal ? mem[idx] : OOB_DATA;
            rsp_oob   <= !rng.legal;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Violations are counted for both reads and writes at acceptance
  sat_counter #(
    .W(COUNT_W)
  ) u_oob_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (acc && !rng.legal),
    .clear(state == ST_INIT),
    .count(oob_count)
  );

endmodule

// File: tb/tb_checked_mem.sv
// tb_checked_mem: directed and random checks of checked_mem against a behavioural model;
// a second instance with COUNT_W=2 covers counter saturation.
module tb_checked_mem;

  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               req_valid, req_ready, req_we;
  logic signed [31:0] req_addr;
  logic [7:0]         req_wdata;
  logic               rsp_valid, rsp_ready;
  logic [7:0]         rsp_data;
  logic               rsp_oob;
  logic [15:0]        oob_count;
  logic               init_done;

  logic               s_valid, s_ready, s_we;
  logic signed [31:0] s_addr;
  logic [7:0]         s_wdata;
  logic               s_rvalid, s_rready;
  logic [7:0]         s_rdata;
  logic               s_oob;
  logic [1:0]         s_count;
  logic               s_done;

  checked_mem dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_oob(rsp_oob), .oob_count(oob_count), .init_done(init_done)
  );

  checked_mem #(.COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_valid), .req_ready(s_ready), .req_we(s_we),
    .req_addr(s_addr), .req_wdata(s_wdata),
    .rsp_valid(s_rvalid), .rsp_ready(s_rready), .rsp_data(s_rdata),
    .rsp_oob(s_oob), .oob_count(s_count), .init_done(s_done)
  );

  // Reference model: contents, pending response and violation count
  logic [7:0]  m_mem [int];
  logic        m_run, m_valid, m_oob;
  logic [7:0]  m_data;
  int unsigned m_count;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = 8'h00;
    m_run = 1'b0; m_valid = 1'b0; m_oob = 1'b0; m_data = 8'h00; m_count = 0;
  endtask

  // One clock of main-DUT traffic; entered and left at a falling edge
  task automatic cycle(input logic v, input logic we, input int addr,
                       input logic [7:0] wd, input logic rr);
    logic exp_ready, legal;
    req_valid = v; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = rr;
    #1;
    exp_ready = m_run && (!m_valid || rr);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    legal = (addr >= 0) && (addr < D);
    if (v && exp_ready && !legal && m_count < 65535) m_count++;
    if (v && exp_ready && we && legal) m_mem[addr] = wd;
    if (v && exp_ready && !we) begin
      m_valid = 1'b1;
      m_data  = legal ? m_mem[addr] : 8'h00;
      m_oob   = !legal;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_eq("rsp_data", 32'(rsp_data), 32'(m_data));
    check_eq("rsp_oob", 32'(rsp_oob), 32'(m_oob));
    check_eq("oob_count", 32'(oob_count), m_count);
    check_eq("init_done", 32'(init_done), 32'(m_run));
  endtask

  // Release reset with a read held on the bus; it must not be taken during INIT
  task automatic init_seq();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 1; req_wdata = 8'h00; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("init_ready_low", 32'(req_ready), 32'd0);
      check_eq("init_done_low", 32'(init_done), 32'd0);
      check_eq("init_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    m_run = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 8'h00; rsp_ready = 1'b0;
    s_valid = 1'b0; s_we = 1'b0; s_addr = 0; s_wdata = 8'h00; s_rready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_oob", 32'(rsp_oob), 32'd0);
    check_eq("rst_oob_count", 32'(oob_count), 32'd0);
    check_eq("rst_init_done", 32'(init_done), 32'd0);

    init_seq();

    // Post-init contents, read-after-write, out-of-range accesses
    for (int a = 0; a < D; a++) cycle(1'b1, 1'b0, a, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 1, 8'hFF, 1'b1);
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 2, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, -1, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 3, 8'hAA, 1'b1);
    for (int a = 0; a < D; a++) cycle(1'b1, 1'b0, a, 8'h00, 1'b1);

    // Backpressure: second read stalls, first response holds
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1);

    // Random traffic over a window slightly wider than the legal range
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 6)) - 2, 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Saturation on the 2-bit counter instance
    s_valid = 1'b1; s_we = 1'b0; s_addr = -1; s_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("sat_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check_eq("sat_count", 32'(s_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check_eq("sat_oob", 32'(s_oob), 32'd1);
    end
    s_valid = 1'b0;

    // Mid-run reset with a response outstanding
    cycle(1'b1, 1'b1, 1, 8'hFF, 1'b1);
    cycle(1'b1, 1'b0, -5, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_oob_count", 32'(oob_count), 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    init_seq();
    cycle(1'b1, 1'b0, 1, 8'h00, 1'b1);
    cycle(1'b1, 1'b0, 0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
